// File: rtl/branch_pred_pkg.sv
// Shared branch-predictor types, defaults and helper functions.
// For CTR_W=2 the counter values keep their usual meaning:
// 3 = strongly taken, 2 = weakly taken, 1 = weakly not taken, 0 = strongly not taken.
package branch_pred_pkg;

  localparam int unsigned DEPTH_DEF    = 64;
  localparam int unsigned CTR_W_DEF    = 2;
  localparam int unsigned HIST_LEN_DEF = 6;

  // Widest counter and index the helpers handle; callers keep the low bits.
  localparam int unsigned CTR_W_MAX = 4;
  localparam int unsigned IDX_W_MAX = 16;

  typedef logic [CTR_W_MAX-1:0] ctr_t;
  typedef logic [IDX_W_MAX-1:0] idx_t;

  // One saturating step of a ctr_w-bit counter toward the resolved direction.
  function automatic ctr_t sat_next(input ctr_t ctr, input logic taken,
                                    input int unsigned ctr_w);
    ctr_t top_v;
    top_v = ctr_t'((1 << ctr_w) - 1);
    if (taken) return (ctr == top_v) ? ctr : ctr + ctr_t'(1);
    else       return (ctr == '0)    ? ctr : ctr - ctr_t'(1);
  endfunction

  // gshare hash: word-aligned PC bits XOR zero-extended history.
  // PC bits above idx_w+1 are discarded.
  function automatic idx_t pht_index(input logic [31:0] pc, input idx_t hist,
                                     input int unsigned idx_w);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return idx_t'((pc >> 2) & mask) ^ hist;
  endfunction

endpackage

// File: rtl/pht_ctr_array.sv
// Counter storage for the pattern history table: one saturating update and
// one registered read per cycle, with write-to-read bypass on a shared index.
module pht_ctr_array
  import branch_pred_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CTR_W = CTR_W_DEF,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_msb,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  // Weakly not taken: the largest value whose MSB is still 0.
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

  logic [CTR_W-1:0] mem [DEPTH];
  logic [CTR_W-1:0] wr_val;
  logic [CTR_W-1:0] rd_ctr;
  ctr_t             wr_full;

  // Post-update value of the entry being written, and the read value with bypass.
  always_comb begin
    wr_full = sat_next(ctr_t'(mem[wr_idx]), wr_taken, CTR_W);
    wr_val  = wr_full[CTR_W-1:0];
    rd_ctr  = (wr_en && (wr_idx == rd_idx)) ? wr_val : mem[rd_idx];
  end

  // Counter storage, its reset initialisation, and the registered read.
  // NOTE: the table must come out of reset weakly-not-taken rather than zero,
  // so every entry is reset explicitly; this keeps it in flops, not a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= CTR_INIT;
      rd_msb <= 1'b0;
    end else begin
      if (wr_en) mem[wr_idx] <= wr_val;
      rd_msb <= rd_en & rd_ctr[CTR_W-1];
    end
  end

endmodule

// File: rtl/gshare_pht.sv
// gshare direction predictor: PC XOR global history indexes a table of
// saturating counters; owns the speculative GHR and its mispredict repair.
module gshare_pht
  import branch_pred_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned CTR_W    = CTR_W_DEF,
  parameter int unsigned HIST_LEN = HIST_LEN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lookup_valid,
  input  logic [31:0]         lookup_pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [HIST_LEN-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [31:0]         upd_pc,
  input  logic [HIST_LEN-1:0] upd_ghr,
  input  logic                upd_taken,
  input  logic                upd_mispredict
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [HIST_LEN-1:0] ghr;
  logic [HIST_LEN-1:0] ghr_spec;
  logic [HIST_LEN-1:0] ghr_fix;
  logic [IDX_W-1:0]    lookup_idx;
  logic [IDX_W-1:0]    upd_idx;
  idx_t                lookup_full;
  idx_t                upd_full;

  // Table indices for the fetch lookup and the resolved-branch update.
  always_comb begin
    lookup_full = pht_index(lookup_pc, idx_t'(ghr), IDX_W);
    upd_full    = pht_index(upd_pc, idx_t'(upd_ghr), IDX_W);
    lookup_idx  = lookup_full[IDX_W-1:0];
    upd_idx     = upd_full[IDX_W-1:0];
  end

  // Next history values: speculative shift of the prediction, or rebuild
  // from the history the mispredicted branch was predicted with.
  if (HIST_LEN == 1) begin : g_hist_one
    assign ghr_spec = pred_taken;
    assign ghr_fix  = upd_taken;
  end else begin : g_hist_many
    assign ghr_spec = {ghr[HIST_LEN-2:0], pred_taken};
    assign ghr_fix  = {upd_ghr[HIST_LEN-2:0], upd_taken};
  end

  pht_ctr_array #(
    .DEPTH (DEPTH),
    .CTR_W (CTR_W),
    .IDX_W (IDX_W)
  ) u_ctr_array (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (lookup_valid),
    .rd_idx   (lookup_idx),
    .rd_msb   (pred_taken),
    .wr_en    (upd_valid),
    .wr_idx   (upd_idx),
    .wr_taken (upd_taken)
  );

  // GHR update (repair beats speculation) and the registered prediction side-band.
  // NOTE: every register here is written with <= so each reads the others'
  // pre-edge values; pred_ghr must capture the GHR before this edge's shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr        <= '0;
      pred_valid <= 1'b0;
      pred_ghr   <= '0;
    end else begin
      if (upd_valid && upd_mispredict) ghr <= ghr_fix;
      else if (pred_valid)             ghr <= ghr_spec;
      pred_valid <= lookup_valid;
      pred_ghr   <= ghr;
    end
  end

endmodule

// File: tb/tb_gshare_pht.sv
// Directed bench for gshare_pht: default instance (CTR_W=2) plus a CTR_W=3
// instance sharing the same inputs, checked with hand-computed values.
module tb_gshare_pht;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [5:0]  upd_ghr;
  logic        upd_taken;
  logic        upd_mispredict;

  logic        pred_valid, pred_taken;
  logic [5:0]  pred_ghr;
  logic        pred_valid3, pred_taken3;
  logic [5:0]  pred_ghr3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gshare_pht dut (
    .clk (clk), .rst (rst),
    .lookup_valid (lookup_valid), .lookup_pc (lookup_pc),
    .pred_valid (pred_valid), .pred_taken (pred_taken), .pred_ghr (pred_ghr),
    .upd_valid (upd_valid), .upd_pc (upd_pc), .upd_ghr (upd_ghr),
    .upd_taken (upd_taken), .upd_mispredict (upd_mispredict)
  );

  gshare_pht #(.DEPTH(64), .CTR_W(3), .HIST_LEN(6)) dut3 (
    .clk (clk), .rst (rst),
    .lookup_valid (lookup_valid), .lookup_pc (lookup_pc),
    .pred_valid (pred_valid3), .pred_taken (pred_taken3), .pred_ghr (pred_ghr3),
    .upd_valid (upd_valid), .upd_pc (upd_pc), .upd_ghr (upd_ghr),
    .upd_taken (upd_taken), .upd_mispredict (upd_mispredict)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then read 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookup_valid = 0; lookup_pc = '0;
    upd_valid = 0; upd_pc = '0; upd_ghr = '0; upd_taken = 0; upd_mispredict = 0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    idle();
    lookup_valid = 1; lookup_pc = pc;
  endtask

  task automatic update(input logic [31:0] pc, input logic [5:0] h, input logic tk,
                        input logic mis);
    upd_valid = 1; upd_pc = pc; upd_ghr = h; upd_taken = tk; upd_mispredict = mis;
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    rst = 0;
    check("reset_valid", 32'(pred_valid), 0);
    check("reset_taken", 32'(pred_taken), 0);
    check("reset_ghr",   32'(pred_ghr),   0);

    // First lookup after reset: idx 0, counter 1 -> not taken.
    lookup(32'h100); step(); idle();
    check("first_valid", 32'(pred_valid), 1);
    check("first_taken", 32'(pred_taken), 0);
    check("first_ghr",   32'(pred_ghr),   0);
    step();
    check("idle_valid", 32'(pred_valid), 0);
    // Not-taken shift keeps GHR at 0; pc 0x200 also maps to idx 0.
    lookup(32'h200); step(); idle();
    check("ghr_after_nt_shift", 32'(pred_ghr), 0);

    // Three taken updates on idx 0: 1 -> 2 -> 3 -> 3; GHR untouched.
    update(32'h100, 6'd0, 1, 0); step();
    update(32'h100, 6'd0, 1, 0); step();
    update(32'h100, 6'd0, 1, 0); step();
    lookup(32'h100); step(); idle();
    check("trained_taken", 32'(pred_taken), 1);
    check("trained_ghr",   32'(pred_ghr),   0);
    // GHR becomes 1; pc 0x104 (idx 1) XOR 1 hits trained idx 0.
    step();
    lookup(32'h104); step(); idle();
    check("hashed_taken", 32'(pred_taken), 1);
    check("hashed_ghr",   32'(pred_ghr),   1);
    step();  // GHR becomes 6'b000011

    // Bypass: lookup pc 0x10 (4^3=7) and taken update pc 0x1C (7^0=7) together.
    lookup(32'h010); update(32'h01C, 6'd0, 1, 0); step(); idle();
    check("bypass_taken", 32'(pred_taken), 1);
    check("bypass_ghr",   32'(pred_ghr),   3);

    // Lookup pc 0x20 (8^3=11, counter 1) -> not taken; GHR shifts to 000111.
    lookup(32'h020); step(); idle();
    check("pre_repair_taken", 32'(pred_taken), 0);
    check("pre_repair_ghr",   32'(pred_ghr),   3);
    // pred_valid=1/pred_taken=0 this cycle; repair must win -> 001011.
    update(32'h040, 6'b000101, 1, 1); step(); idle();
    lookup(32'h000); step(); idle();
    check("repair_ghr",   32'(pred_ghr),   32'b001011);
    check("repair_taken", 32'(pred_taken), 0);

    // Reset together with a lookup and an update after training.
    rst = 1; lookup(32'h100); update(32'h100, 6'd0, 1, 0); step();
    rst = 0; idle();
    check("rst_valid", 32'(pred_valid), 0);
    lookup(32'h100); step(); idle();
    check("post_rst_valid", 32'(pred_valid), 1);
    check("post_rst_taken", 32'(pred_taken), 0);
    check("post_rst_ghr",   32'(pred_ghr),   0);
    step();  // not-taken shift, GHR stays 0

    // CTR_W=3 instance: idx 0 starts at 3; eight not-taken updates -> 0, one taken -> 1.
    for (int i = 0; i < 8; i++) begin
      update(32'h100, 6'd0, 0, 0); step();
    end
    update(32'h100, 6'd0, 1, 0); step();
    lookup(32'h100); step(); idle();
    check("w3_sat_low_taken", 32'(pred_taken3), 0);
    check("w3_sat_low_ghr",   32'(pred_ghr3),   0);
    step();
    // Three more taken: 1 -> 4, MSB of a 3-bit counter now set.
    for (int i = 0; i < 3; i++) begin
      update(32'h100, 6'd0, 1, 0); step();
    end
    lookup(32'h100); step(); idle();
    check("w3_msb_taken", 32'(pred_taken3), 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gshare_pht.md
# gshare_pht

Parametrised gshare direction predictor for the front end: a pattern history table of CTR_W-bit saturating counters indexed by PC XOR a global history register (GHR). It takes one lookup per cycle from fetch and returns a registered prediction with a history snapshot one cycle later. It takes one resolved-branch update per cycle from commit/branch resolution, and repairs the speculative GHR on mispredict. It generalises the fixed 2-bit, PC-indexed counter file to configurable depth, counter width and history length, adding history tracking and write-to-read bypass.

## Interface
- DEPTH, 64, PHT entries; power of two ≥ 4; IDX_W = $clog2(DEPTH)
- CTR_W, 2, counter width, 2..4
- HIST_LEN, 6, GHR bits; 1 ≤ HIST_LEN ≤ IDX_W
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- lookup_valid  in  1  fetch requests a prediction this cycle
- lookup_pc  in  32  PC of fetched branch
- pred_valid  out  1  prediction valid (registered)
- pred_taken  out  1  predicted direction = counter MSB
- pred_ghr  out  HIST_LEN  GHR value used to form the lookup index
- upd_valid  in  1  resolved branch update this cycle
- upd_pc  in  32  PC of resolved branch
- upd_ghr  in  HIST_LEN  pred_ghr carried with that branch
- upd_taken  in  1  actual direction
- upd_mispredict  in  1  the prediction for this branch was wrong

## Operation
- Index: idx(pc, h) = pc[IDX_W+1:2] XOR zero_extend(h, IDX_W).
- Lookup: read counter[idx(lookup_pc, GHR)]. Register pred_taken = MSB, pred_ghr = current GHR, pred_valid = lookup_valid.
- Update: when upd_valid, counter[idx(upd_pc, upd_ghr)] saturates toward the outcome:
  - taken: +1, holding at 2^CTR_W−1
  - not taken: −1, holding at 0
  - Only one entry is written per cycle.
- Bypass: if a lookup and an update hit the same index in the same cycle, the prediction uses the post-update value.
- GHR speculative shift: on the edge ending a cycle with pred_valid=1, GHR <= {GHR[HIST_LEN-2:0], pred_taken}. For HIST_LEN=1, GHR <= pred_taken.
- GHR repair: when upd_valid && upd_mispredict, GHR <= {upd_ghr[HIST_LEN-2:0], upd_taken}. Repair overrides a same-cycle speculative shift.
- upd_valid without upd_mispredict leaves the GHR unchanged.
- Reset values:
  - every counter = 2^(CTR_W−1)−1 (weakly not taken)
  - GHR = 0
  - pred_valid = 0, pred_taken = 0, pred_ghr = 0

## Timing
- Lookup-to-prediction latency: exactly 1 cycle; sustains one lookup per cycle.
- Back-to-back lookups: a lookup in cycle t+1 uses the GHR before the shift from cycle t's lookup (that shift lands at the end of t+1). This is intended; pred_ghr reports the value actually used.
- An update in cycle t is visible to a lookup in cycle t (bypass) and to all later lookups.
- No backpressure: outputs are valid for one cycle only; the consumer must capture them.
- Reset asserted in cycle t:
  - pred_valid = 0 in cycle t+1 regardless of lookup_valid
  - updates and lookups in cycle t are discarded
  - all state is initialised by the end of cycle t; single-cycle reset suffices
- Counter and GHR arithmetic wraps nowhere: saturation only; upper index bits are discarded above IDX_W+1.

## Structure
- Shared package branch_pred_pkg:
  - default DEPTH/CTR_W/HIST_LEN constants
  - pure function sat_next(ctr, taken) for the saturating step
  - function pht_index(pc, hist) for the XOR hash
  - The existing CDB_types ST/WT/WN/SN encodings remain the CTR_W=2 meaning; no new enum is needed.
- Sub-module pht_ctr_array: counter storage, reset init, saturating update, same-cycle bypass, registered read.
- Top gshare_pht owns the GHR, index hashing and the pred_* registers.

## Test plan
- After reset, lookup pc=0x100: next cycle pred_valid=1, pred_taken=0, pred_ghr=0; the cycle after, GHR=0.
- Three taken updates, pc=0x100, upd_ghr=0, no lookups; then lookup pc=0x100: counter 1→2→3→3, pred_taken=1, GHR stays 0.
- CTR_W=3: eight not-taken updates on one entry (3→0, saturates), one taken (→1), then lookup: pred_taken=0.
- Entry at 1, taken update and lookup to the same index in the same cycle: pred_taken=1 next cycle (bypass).
- upd_mispredict with upd_ghr=6'b000101, upd_taken=1, in the same cycle as pred_valid=1/pred_taken=0: GHR=6'b001011 next cycle (repair wins).
- rst=1 together with lookup_valid=1 and an update, after prior training: next cycle pred_valid=0; a subsequent lookup returns pred_taken=0 and pred_ghr=0.
